// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the ysyx_24080006 fetch path: icache FSM
// states, AXI read-channel encodings and the AXI read-channel bundles.
package ysyx_24080006_pkg;

    typedef enum logic [2:0] {
        IC_IDLE,
        IC_LOOKUP,
        IC_MISS_AR,
        IC_MISS_R,
        IC_BYP_AR,
        IC_BYP_R,
        IC_RESP
    } icache_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [31:0] araddr;
        logic        arvalid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } axi_r_s2m_t;

endpackage

// File: rtl/ysyx_24080006_icache_array.sv
// Tag and data storage for the direct-mapped icache. Writes are synchronous,
// reads are combinational so a lookup resolves in a single cycle. Valid bits
// live in the parent so a fence can wipe them all at once.
module ysyx_24080006_icache_array #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    localparam int IW = $clog2(NUM_LINES),
    localparam int OW = $clog2(LINE_WORDS)
) (
    input  logic             clock,
    input  logic [IW-1:0]    index,
    input  logic             data_we,
    input  logic [OW-1:0]    w_word,
    input  logic [31:0]      w_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] w_tag,
    input  logic [OW-1:0]    r_word,
    output logic [31:0]      r_data,
    output logic [TAG_W-1:0] r_tag
);

    logic [31:0]      data_mem [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];

    // Refill beats and the closing tag write land on the clock edge; storage is never reset.
    always_ff @(posedge clock) begin
        if (data_we) begin
            data_mem[index][w_word] <= w_data;
        end
        if (tag_we) begin
            tag_mem[index] <= w_tag;
        end
    end

    assign r_data = data_mem[index][r_word];
    assign r_tag  = tag_mem[index];

endmodule

// File: rtl/ysyx_24080006_icache.sv
// Direct-mapped read-only instruction cache in front of the fetch FSM.
// Misses refill a whole line with an INCR burst; the uncached window is
// served with single-beat reads; fence.i invalidates every line.
module ysyx_24080006_icache
    import ysyx_24080006_pkg::*;
#(
    parameter int          NUM_LINES     = 16,
    parameter int          LINE_WORDS    = 4,
    parameter logic [31:0] UNCACHED_BASE = 32'h0f00_0000,
    parameter logic [31:0] UNCACHED_MASK = 32'hff00_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fencei,
    input  logic        ifu2icu_valid,
    output logic        icu2ifu_ready,
    input  logic [31:0] fetch_addr,
    output logic        icu2ifu_valid,
    input  logic        ifu2icu_ready,
    output logic [31:0] ic_val,
    output logic        icache_hit,
    output logic        icache_miss,
    output logic        icache_skip,
    output axi_r_m2s_t  ifu_r_m2s,
    input  axi_r_s2m_t  ifu_r_s2m
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int TW = 32 - IW - OW - 2;
    localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

    icache_state_e          state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic                   fence_pend_q, fence_pend_d;
    logic [31:0]            req_addr_q, req_addr_d;
    logic [OW-1:0]          beat_q, beat_d;
    logic                   err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            ic_val_q, ic_val_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic                   skip_q, skip_d;
    logic                   arvalid_q, arvalid_d;
    logic [31:0]            araddr_q, araddr_d;
    logic [7:0]             arlen_q, arlen_d;
    logic                   rready_q, rready_d;

    logic [IW-1:0]          req_idx;
    logic [OW-1:0]          req_off;
    logic [TW-1:0]          req_tag;
    logic                   uncached;
    logic                   r_fire;
    logic                   last_beat;
    logic                   beat_err;
    logic                   arr_data_we;
    logic                   arr_tag_we;
    logic [31:0]            rd_data;
    logic [TW-1:0]          rd_tag;

    assign req_off   = req_addr_q[OW+1:2];
    assign req_idx   = req_addr_q[OW+IW+1:OW+2];
    assign req_tag   = req_addr_q[31:OW+IW+2];
    assign uncached  = (req_addr_q & UNCACHED_MASK) == UNCACHED_BASE;
    assign r_fire    = ifu_r_s2m.rvalid & rready_q;
    assign last_beat = (beat_q == LAST_BEAT) | ifu_r_s2m.rlast;
    assign beat_err  = err_q | (ifu_r_s2m.rresp != AXI_RESP_OKAY);

    ysyx_24080006_icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TW)
    ) u_array (
        .clock   (clock),
        .index   (req_idx),
        .data_we (arr_data_we),
        .w_word  (beat_q),
        .w_data  (ifu_r_s2m.rdata),
        .tag_we  (arr_tag_we),
        .w_tag   (req_tag),
        .r_word  (req_off),
        .r_data  (rd_data),
        .r_tag   (rd_tag)
    );

    // Next-state logic for the whole controller; every output is computed here and registered below.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        fence_pend_d = fence_pend_q | fencei;
        req_addr_d   = req_addr_q;
        beat_d       = beat_q;
        err_d        = err_q;
        ready_d      = 1'b0;
        resp_valid_d = resp_valid_q;
        ic_val_d     = ic_val_q;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        skip_d       = 1'b0;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        rready_d     = rready_q;
        arr_data_we  = 1'b0;
        arr_tag_we   = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                if (fence_pend_q || fencei) begin
                    valid_d      = '0;
                    fence_pend_d = 1'b0;
                    ready_d      = 1'b1;
                end else if (ifu2icu_valid && ready_q) begin
                    req_addr_d = fetch_addr & ~32'h3;
                    state_d    = IC_LOOKUP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            IC_LOOKUP: begin
                if (uncached) begin
                    skip_d    = 1'b1;
                    arvalid_d = 1'b1;
                    araddr_d  = req_addr_q;
                    arlen_d   = 8'd0;
                    state_d   = IC_BYP_AR;
                end else if (valid_q[req_idx] && (rd_tag == req_tag)) begin
                    hit_d        = 1'b1;
                    ic_val_d     = rd_data;
                    resp_valid_d = 1'b1;
                    state_d      = IC_RESP;
                end else begin
                    // The line is about to be overwritten, so it must not look valid under its old tag.
                    miss_d           = 1'b1;
                    valid_d[req_idx] = 1'b0;
                    arvalid_d        = 1'b1;
                    araddr_d         = {req_addr_q[31:OW+2], {(OW+2){1'b0}}};
                    arlen_d          = 8'(LINE_WORDS - 1);
                    state_d          = IC_MISS_AR;
                end
            end
            IC_MISS_AR: begin
                if (ifu_r_s2m.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    state_d   = IC_MISS_R;
                end
            end
            IC_MISS_R: begin
                if (r_fire) begin
                    arr_data_we = 1'b1;
                    beat_d      = beat_q + 1'b1;
                    err_d       = beat_err;
                    if (beat_q == req_off) begin
                        ic_val_d = ifu_r_s2m.rdata;
                    end
                    if (last_beat) begin
                        arr_tag_we = 1'b1;
                        if (!beat_err && !fence_pend_q && !fencei && (beat_q == LAST_BEAT)) begin
                            valid_d[req_idx] = 1'b1;
                        end
                        rready_d     = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = IC_RESP;
                    end
                end
            end
            IC_BYP_AR: begin
                if (ifu_r_s2m.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = IC_BYP_R;
                end
            end
            IC_BYP_R: begin
                if (r_fire) begin
                    ic_val_d     = ifu_r_s2m.rdata;
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = IC_RESP;
                end
            end
            IC_RESP: begin
                if (ifu2icu_ready) begin
                    resp_valid_d = 1'b0;
                    ready_d      = ~fence_pend_d;
                    state_d      = IC_IDLE;
                end
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase
    end

    // Single state register for the FSM and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IC_IDLE;
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
            req_addr_q   <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            ic_val_q     <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            skip_q       <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            rready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fence_pend_q <= fence_pend_d;
            req_addr_q   <= req_addr_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            ic_val_q     <= ic_val_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            skip_q       <= skip_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            rready_q     <= rready_d;
        end
    end

    assign icu2ifu_ready = ready_q;
    assign icu2ifu_valid = resp_valid_q;
    assign ic_val        = ic_val_q;
    assign icache_hit    = hit_q;
    assign icache_miss   = miss_q;
    assign icache_skip   = skip_q;

    // Pack the registered AR/R master signals; size and burst type never change.
    always_comb begin
        ifu_r_m2s         = '0;
        ifu_r_m2s.araddr  = araddr_q;
        ifu_r_m2s.arvalid = arvalid_q;
        ifu_r_m2s.arlen   = arlen_q;
        ifu_r_m2s.arsize  = AXI_SIZE_4B;
        ifu_r_m2s.arburst = AXI_BURST_INCR;
        ifu_r_m2s.rready  = rready_q;
    end

endmodule

// File: doc/ysyx_24080006_icache.md
Name: ysyx_24080006_icache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch FSM.
- Accepts one word-aligned fetch request at a time and returns one 32-bit word.
- On a miss, refills a full line from memory over the AXI read channel using an INCR burst.
- Addresses in the uncached window are fetched with single-beat AXI reads, bypassing the arrays; fence.i invalidates every line.

Parameters:
- NUM_LINES, 16: number of lines; power of 2, at least 2; index width IW = log2(NUM_LINES).
- LINE_WORDS, 4: 32-bit words per line; power of 2; word offset width OW = log2(LINE_WORDS).
- UNCACHED_BASE, 32'h0f00_0000: base of the uncached window.
- UNCACHED_MASK, 32'hff00_0000: an address is uncached when (addr & mask) == base.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fencei  in  1  one-cycle pulse: invalidate all lines
- ifu2icu_valid  in  1  fetch request valid; held until accepted
- icu2ifu_ready  out  1  request can be accepted
- fetch_addr  in  32  request address; bits [1:0] are ignored
- icu2ifu_valid  out  1  response valid; held until taken
- ifu2icu_ready  in  1  consumer takes the response
- ic_val  out  32  response instruction word
- icache_hit  out  1  one-cycle pulse on a cacheable hit
- icache_miss  out  1  one-cycle pulse on a cacheable miss
- icache_skip  out  1  one-cycle pulse on an uncached access
- ifu_r_m2s  out  axi_r_m2s_t  AR and R master signals: araddr, arvalid, arlen, arsize, arburst, rready
- ifu_r_s2m  in  axi_r_s2m_t  slave signals: arready, rvalid, rdata, rresp, rlast

Behaviour:
- Reset, asynchronous on reset low:
  - state = IDLE, all valid bits = 0, fence_pend = 0.
  - icu2ifu_valid = 0, icu2ifu_ready = 0, ic_val = 0.
  - arvalid = 0, rready = 0, araddr = 0.
  - Hit, miss and skip pulses = 0.
  - Tag and data arrays are not reset.
- icu2ifu_ready = 1 only in IDLE with fence_pend = 0.
- Accept happens when ifu2icu_valid & icu2ifu_ready. On accept, latch req_addr = {fetch_addr[31:2], 2'b00}.
- Address split:
  - word offset = req_addr[OW+1:2]
  - index = req_addr[OW+IW+1:OW+2]
  - tag = req_addr[31:OW+IW+2]
- States: IDLE, LOOKUP, MISS_AR, MISS_R, BYP_AR, BYP_R, RESP.
- IDLE:
  - If fence_pend or fencei: clear all valid bits this cycle, clear fence_pend, stay in IDLE.
  - Otherwise, on accept go to LOOKUP.
- LOOKUP (one cycle):
  - Uncached address: pulse icache_skip, go to BYP_AR.
  - Cacheable and valid[index] with matching tag: pulse icache_hit, register ic_val from the data array, set icu2ifu_valid, go to RESP.
  - Otherwise: pulse icache_miss, go to MISS_AR.
  - Hit latency: response valid 2 cycles after the accept edge.
- MISS_AR:
  - arvalid = 1, araddr = line base (offset bits zeroed).
  - arlen = LINE_WORDS-1, arsize = 3'b010, arburst = INCR.
  - Hold all AR fields stable until arready; then drop arvalid, go to MISS_R with beat counter = 0.
- MISS_R:
  - rready = 1.
  - Each beat writes rdata into data[index][beat] and increments beat.
  - When beat == word offset, capture rdata into ic_val.
  - The final beat is beat == LINE_WORDS-1, or rlast, whichever comes first. On it:
    - Write the tag.
    - Set valid[index] only if every rresp was OKAY (sticky error flag) and no fence arrived during the refill.
    - Set icu2ifu_valid, go to RESP.
  - rlast asserted early: the line is not validated.
- BYP_AR: arvalid = 1, araddr = req_addr, arlen = 0, arsize = 3'b010. On arready go to BYP_R.
- BYP_R: rready = 1. On the first beat, ic_val = rdata, set icu2ifu_valid, go to RESP. No array write.
- RESP: hold icu2ifu_valid and ic_val stable until ifu2icu_ready, then clear icu2ifu_valid and return to IDLE.
- fencei outside IDLE: set fence_pend. The in-flight line is written but not validated; invalidation happens on the next IDLE cycle, and no request is accepted that cycle.
- fencei in the same cycle as an accept attempt: the fence wins and the request is not accepted.
- rresp error: data is still returned to the IFU; the line stays invalid.
- Requests that fetch_addr changes while ifu2icu_valid is high and not yet accepted are undefined; the IFU must hold it.

Decomposition:
- Shared package (ysyx_24080006_pkg) holds:
  - icache_state_e
  - AXI burst and size constants: AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY
  - the existing axi_r_m2s_t and axi_r_s2m_t types
- One sub-module, ysyx_24080006_icache_array:
  - Tag plus data storage.
  - Synchronous write, combinational read.
  - Parameterised by NUM_LINES and LINE_WORDS.
  - Valid bits stay in the parent so fence clearing is single-cycle.

Test Plan:
- Cold miss at 0x3000_0014, arready after 2 cycles, 4 beats 0x11,0x22,0x33,0x44 -> araddr = 0x3000_0010, arlen = 3, icache_miss pulse, ic_val = 0x22, line valid.
- Repeat 0x3000_0018 -> icache_hit pulse, no arvalid, ic_val = 0x33 valid exactly 2 cycles after the accept edge.
- Hold ifu2icu_ready = 0 for 5 cycles after a hit -> icu2ifu_valid and ic_val stable; icu2ifu_ready = 0 until the handshake completes.
- Access 0x0f00_0040 -> icache_skip pulse, arlen = 0, araddr = 0x0f00_0040, ic_val = rdata; a second access also issues AR (not cached).
- fencei pulse during MISS_R, then re-fetch the same line -> refill completes and the word is returned; next access is a miss.
- rresp = SLVERR on beat 2 of a refill -> word returned; the following access to the same line misses.
- Drive reset low mid-MISS_R -> all outputs 0 immediately (asynchronous); after release, the first access misses.
